// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if -- request/grant bundle between eight requesters and the
// round-robin arbiter.
//
// Handshake: a requester raises iReq[i] and keeps it high for as long as it
// wants the slot. The arbiter answers with oValid=1 and a one-hot oGrant
// (index in oGrantId). The holder ends the transfer by pulsing iDone, or by
// dropping its iReq bit. oTimeout pulses for one cycle when the arbiter
// takes the slot back because the hold limit was reached.
//
// Signals:
//   iReq      8  request vector, bit i = requester i
//   iDone     1  holder finished (only meaningful while oValid=1)
//   oGrant    8  one-hot grant, zero when idle
//   oGrantId  3  binary index of the holder, zero when idle
//   oValid    1  grant active
//   oTimeout  1  one-cycle pulse after a timeout-only release
//   dbgState  1  FSM state (0=IDLE, 1=GRANT), for observation only
//   dbgPtr    3  rotating-priority pointer, for observation only
interface rr_arbiter8_if;
  logic [7:0] iReq;
  logic       iDone;
  logic [7:0] oGrant;
  logic [2:0] oGrantId;
  logic       oValid;
  logic       oTimeout;
  logic       dbgState;
  logic [2:0] dbgPtr;

  // Arbiter side.
  modport slave (
    input  iReq, iDone,
    output oGrant, oGrantId, oValid, oTimeout, dbgState, dbgPtr
  );

  // Requester / environment side.
  modport master (
    output iReq, iDone,
    input  oGrant, oGrantId, oValid, oTimeout, dbgState, dbgPtr
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin arbiter sharing one resource slot among eight
// requesters.
//
// In IDLE the first set bit of iReq, searching upward from ptr and wrapping,
// wins and is granted one edge later. The grant is held until the holder
// pulses iDone, withdraws its request, or has held for MAX_HOLD cycles. On
// release ptr moves to holder+1, so the released requester has the lowest
// priority next time. Every release passes through one IDLE cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_arbiter8_if.slave (iReq, iDone in; oGrant, oGrantId, oValid,
//        oTimeout, dbgState, dbgPtr out). All outputs are registered.
//
// Parameter:
//   MAX_HOLD  maximum cycles a grant may be held (2..255)
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter8_if.slave       bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} stateT;

  stateT      state, stateNext;
  logic [2:0] ptr, ptrNext;
  logic [7:0] cnt, cntNext;
  logic [7:0] grantNext;
  logic [2:0] idNext;
  logic       validNext;
  logic       timeoutNext;

  // Rotating-priority search result.
  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;

  // Release causes while in GRANT.
  logic relDone, relWithdraw, relLimit;

  always_comb begin
    winner = 3'd0;
    cand   = 3'd0;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);  // wraps naturally in 3 bits
      if (!found && bus.iReq[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign relDone     = bus.iDone;
  assign relWithdraw = !bus.iReq[bus.oGrantId];
  assign relLimit    = (cnt == 8'(MAX_HOLD));

  always_comb begin
    stateNext   = state;
    ptrNext     = ptr;
    cntNext     = cnt;
    grantNext   = bus.oGrant;
    idNext      = bus.oGrantId;
    validNext   = bus.oValid;
    timeoutNext = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          stateNext = GRANT;
          grantNext = 8'd1 << winner;
          idNext    = winner;
          validNext = 1'b1;
          cntNext   = 8'd1;
        end
      end
      GRANT: begin
        if (relDone || relWithdraw || relLimit) begin
          stateNext   = IDLE;
          grantNext   = 8'd0;
          idNext      = 3'd0;
          validNext   = 1'b0;
          cntNext     = 8'd0;
          ptrNext     = bus.oGrantId + 3'd1;
          // A timeout is flagged only when the limit is the sole cause.
          timeoutNext = relLimit && !relDone && !relWithdraw;
        end else begin
          cntNext = cnt + 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 3'd0;
      cnt          <= 8'd0;
      bus.oGrant   <= 8'd0;
      bus.oGrantId <= 3'd0;
      bus.oValid   <= 1'b0;
      bus.oTimeout <= 1'b0;
    end else begin
      state        <= stateNext;
      ptr          <= ptrNext;
      cnt          <= cntNext;
      bus.oGrant   <= grantNext;
      bus.oGrantId <= idNext;
      bus.oValid   <= validNext;
      bus.oTimeout <= timeoutNext;
    end
  end

  assign bus.dbgState = state;
  assign bus.dbgPtr   = ptr;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8 -- directed bench for rr_arbiter8 (MAX_HOLD = 16).
// A table of single-edge vectors covers reset, single grant, pointer wrap and
// skip, withdrawal, non-holder requests, iDone in IDLE and reset mid-grant.
// Hand-written sequences cover full rotation, timeout and the iDone/limit
// coincidence.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;

  logic clk;
  logic rst;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] id;
    logic       valid;
    logic       timeout;
    logic [2:0] ptr;
  } vecT;

  vecT        vecs[$];
  logic [2:0] expQ[$];
  int         nVec;
  int         nMis;

  function automatic vecT mk(logic r, logic [7:0] q, logic d, logic [7:0] g,
                             logic [2:0] id, logic v, logic t, logic [2:0] p);
    vecT x;
    x.rst = r; x.req = q; x.done = d; x.grant = g;
    x.id = id; x.valid = v; x.timeout = t; x.ptr = p;
    return x;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [7:0] q, input logic d);
    rst      = r;
    bus.iReq = q;
    bus.iDone = d;
  endtask

  task automatic chkOut(input string name, input int idx, input logic [7:0] g,
                        input logic [2:0] id, input logic v, input logic t);
    chk({name, ".grant"},   idx, bus.oGrant, g);
    chk({name, ".id"},      idx, 8'(bus.oGrantId), 8'(id));
    chk({name, ".valid"},   idx, 8'(bus.oValid), 8'(v));
    chk({name, ".timeout"}, idx, 8'(bus.oTimeout), 8'(t));
  endtask

  task automatic doReset();
    drive(1'b1, 8'h00, 1'b0);
    tick();
    tick();
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    drive(1'b1, 8'h00, 1'b0);

    //             rst  req    done grant  id    v     t     ptr
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0));
    // Single request, then iDone.
    vecs.push_back(mk(1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd3));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd3));
    // Requester 6 released -> ptr 7, then wrap to 0 and skip back to 6.
    vecs.push_back(mk(1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, 3'd3));
    vecs.push_back(mk(1'b0, 8'h40, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd7));
    vecs.push_back(mk(1'b0, 8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd7));
    vecs.push_back(mk(1'b0, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd7));
    // Withdrawal at cnt=5: no timeout pulse.
    vecs.push_back(mk(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd7));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd7));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd4));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd4));
    // Reset mid-grant on id 5, then all request -> id 0.
    vecs.push_back(mk(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd4));
    vecs.push_back(mk(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd4));
    vecs.push_back(mk(1'b1, 8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1));
    // iDone in IDLE does nothing.
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1));
    // Non-holder request during GRANT is ignored, seen at next IDLE.
    vecs.push_back(mk(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 8'h06, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd3));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].done);
      tick();
      chkOut("table", i, vecs[i].grant, vecs[i].id, vecs[i].valid, vecs[i].timeout);
      chk("table.ptr", i, 8'(bus.dbgPtr), 8'(vecs[i].ptr));
    end

    // Full contention rotation: 0..7,0 with one IDLE cycle between grants.
    doReset();
    for (int g = 0; g < 9; g++) expQ.push_back(3'(g % 8));
    bus.iReq = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      logic [2:0] e;
      e = expQ.pop_front();
      bus.iDone = 1'b0;
      tick();
      chkOut("rot.grant", g, 8'd1 << e, e, 1'b1, 1'b0);
      bus.iDone = 1'b1;
      tick();
      chkOut("rot.idle", g, 8'h00, 3'd0, 1'b0, 1'b0);
    end
    bus.iDone = 1'b0;

    // Timeout: requester 4 held for exactly MAX_HOLD cycles.
    doReset();
    bus.iReq = 8'h10;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      chkOut("to.hold", c, 8'h10, 3'd4, 1'b1, 1'b0);
    end
    tick();
    chkOut("to.pulse", 0, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("to.ptr", 0, 8'(bus.dbgPtr), 8'd5);
    tick();
    chkOut("to.regrant", 0, 8'h10, 3'd4, 1'b1, 1'b0);

    // Coincidence: iDone at cnt == MAX_HOLD releases without timeout.
    for (int c = 1; c < MAX_HOLD; c++) begin
      tick();
      chkOut("co.hold", c, 8'h10, 3'd4, 1'b1, 1'b0);
    end
    bus.iDone = 1'b1;
    tick();
    chkOut("co.release", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    bus.iDone = 1'b0;
    bus.iReq  = 8'h00;
    tick();
    chkOut("co.idle", 0, 8'h00, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
